// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock; done pulses BIN_WIDTH edges after start is accepted.
// No backpressure: start is ignored while busy, and the result registers hold until the next completion edge.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGITS-1:0]    bcd,
  output logic [DIGITS-1:0]      blank
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CW   = $clog2(BIN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              r_state, w_state_nxt;
  logic [BIN_WIDTH-1:0] r_bin, w_bin_nxt;
  logic [BCDW-1:0]     r_work, w_work_nxt;
  logic [BCDW-1:0]     r_bcd, w_bcd_nxt;
  logic [BCDW-1:0]     w_adj, w_shifted;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [DIGITS-1:0]   r_blank, w_blank_nxt, w_blank_new;
  logic                r_done, w_done_nxt;

  // Per-digit add-3 stays within each nibble; only the shift moves bits between digits.
  always_comb begin
    logic w_allz;
    w_adj = r_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
      end
    end
    w_shifted   = {w_adj[BCDW-2:0], r_bin[BIN_WIDTH-1]};
    w_blank_new = '0;
    w_allz      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_allz         = w_allz & (w_shifted[4*i +: 4] == 4'd0);
      w_blank_new[i] = w_allz;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    w_blank_nxt = r_blank;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_bin_nxt   = bin;
          w_work_nxt  = '0;
          w_cnt_nxt   = CW'(BIN_WIDTH);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_work_nxt = w_shifted;
        w_bin_nxt  = {r_bin[BIN_WIDTH-2:0], 1'b0};
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_bcd_nxt   = w_shifted;
          w_blank_nxt = w_blank_new;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
      r_blank <= w_blank_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy  = (r_state == SHIFT);
  assign done  = r_done;
  assign bcd   = r_bcd;
  assign blank = r_blank;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed literal cases plus random stimulus against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;
  localparam int BW = 16;
  localparam int ND = 5;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [BW-1:0]   bin;
  logic            busy;
  logic            done;
  logic [4*ND-1:0] bcd;
  logic [ND-1:0]   blank;

  int total = 0;
  int bad   = 0;
  logic en_cmp = 1'b0;

  bin_to_bcd_seq #(.BIN_WIDTH(BW), .DIGITS(ND)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit i and everything above it are zero exactly when the value is below 10^i.
  function automatic logic [ND-1:0] blank_of(input int v);
    logic [ND-1:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 1; i < ND; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  // Reference model: a conversion accepted on one edge completes BW edges later.
  int              cyc = 0;
  int              m_fin = 0;
  int              m_op = 0;
  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  logic [4*ND-1:0] m_bcd = '0;
  logic [ND-1:0]   m_blank = 5'b11110;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_bcd   <= '0;
      m_blank <= 5'b11110;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (cyc == m_fin) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_bcd   <= to_bcd(m_op);
          m_blank <= blank_of(m_op);
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_op   <= int'(bin);
        m_fin  <= cyc + BW;
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_bcd", 32'(bcd), 32'(m_bcd));
      chk("model_blank", 32'(blank), 32'(m_blank));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a conversion, optionally pulses a stray start at edge inj_at after acceptance,
  // and returns the number of edges from acceptance until done is seen.
  task automatic run_conv(input logic [BW-1:0] v, input int inj_at,
                          input logic [BW-1:0] inj_v, output int lat);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = 16'hA5A5;
    lat   = 0;
    while (lat < 40) begin
      if (lat == inj_at - 1) begin
        start = 1'b1;
        bin   = inj_v;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (done) break;
      chk("busy_during", 32'(busy), 32'd1);
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(lat), 32'd16);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    start = 1'b0;
    bin   = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_blank", 32'(blank), 32'b11110);
    en_cmp = 1'b1;
    repeat (2) tick();

    // Start present on the first edge after reset release: bin=0.
    rst_n = 1'b1;
    run_conv(16'd0, 0, 16'd0, lat);
    chk("zero_lat", 32'(lat), 32'd16);
    chk("zero_bcd", 32'(bcd), 32'h00000);
    chk("zero_blank", 32'(blank), 32'b11110);
    tick();
    chk("zero_done_once", 32'(done), 32'd0);

    run_conv(16'd65535, 0, 16'd0, lat);
    chk("max_lat", 32'(lat), 32'd16);
    chk("max_bcd", 32'(bcd), 32'h65535);
    chk("max_blank", 32'(blank), 32'b00000);
    tick();

    run_conv(16'd1234, 5, 16'd9, lat);
    chk("ign_lat", 32'(lat), 32'd16);
    chk("ign_bcd", 32'(bcd), 32'h01234);
    chk("ign_blank", 32'(blank), 32'b10000);

    // Back-to-back: start issued in the done cycle.
    run_conv(16'd100, 0, 16'd0, lat);
    chk("b2b_gap", 32'(lat + 1), 32'd17);
    chk("b2b_bcd", 32'(bcd), 32'h00100);
    chk("b2b_blank", 32'(blank), 32'b11000);
    tick();

    // Reset in the middle of a conversion.
    start = 1'b1;
    bin   = 16'd4095;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("no_done_after_rst", 32'(done), 32'd0);
    end
    run_conv(16'd4095, 0, 16'd0, lat);
    chk("post_rst_lat", 32'(lat), 32'd16);
    chk("post_rst_bcd", 32'(bcd), 32'h04095);
    chk("post_rst_blank", 32'(blank), 32'b10000);
    tick();

    // Random sweep: mostly-high start with stray pulses while busy, checked by the model.
    for (int c = 0; c < 60000; c++) begin
      start = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 9))
        0:       bin = 16'd0;
        1:       bin = 16'hFFFF;
        2:       bin = 16'd9999;
        3:       bin = 16'd10000;
        default: bin = 16'($urandom);
      endcase
      tick();
    end
    start = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
